// File: rtl/uart_tx_fifo_pkg.sv
// Shared definitions for the UART transmit buffer: default widths and
// issue-FSM state encodings.
package uart_tx_fifo_pkg;

  localparam int DBIT_DEF   = 8;
  localparam int ADDR_W_DEF = 4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_ISSUE = 2'b01,
    ST_WAIT  = 2'b10
  } issue_state_e;

endpackage

// File: rtl/uart_fifo_mem.sv
// Register file backing the UART transmit FIFO: synchronous write,
// asynchronous read, no reset on the storage itself.
module uart_fifo_mem
  import uart_tx_fifo_pkg::*;
#(
  parameter int DBIT   = DBIT_DEF,
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic              clk,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DBIT-1:0]   wr_data,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DBIT-1:0]   rd_data
);

  localparam int DEPTH = 2 ** ADDR_W;

  logic [DBIT-1:0] mem_r [DEPTH];

  // storage write port
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_r[wr_addr] <= wr_data;
    end
  end

  assign rd_data = mem_r[rd_addr];

endmodule

// File: rtl/uart_tx_fifo.sv
// Byte FIFO plus issue controller feeding the UART transmitter one byte at a
// time over the tx_start / tx_din / tx_done_tick handshake.
module uart_tx_fifo
  import uart_tx_fifo_pkg::*;
#(
  parameter int DBIT   = DBIT_DEF,
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            wr_en,
  input  logic [DBIT-1:0] wr_data,
  output logic            full,
  output logic            empty,
  output logic [ADDR_W:0] level,
  output logic            overflow,
  output logic            tx_start,
  output logic [DBIT-1:0] tx_din,
  input  logic            tx_done_tick,
  output logic            busy
);

  localparam logic [ADDR_W:0]   LVL_FULL = {1'b1, {ADDR_W{1'b0}}};
  localparam logic [ADDR_W:0]   LVL_ZERO = {(ADDR_W+1){1'b0}};
  localparam logic [ADDR_W:0]   LVL_ONE  = (ADDR_W+1)'(1);
  localparam logic [ADDR_W-1:0] PTR_ZERO = {ADDR_W{1'b0}};
  localparam logic [ADDR_W-1:0] PTR_ONE  = ADDR_W'(1);
  localparam logic [DBIT-1:0]   DIN_ZERO = {DBIT{1'b0}};

  issue_state_e      state_r, state_next_s;
  logic [ADDR_W-1:0] wr_ptr_r, rd_ptr_r;
  logic [ADDR_W:0]   level_r, level_next_s;
  logic              full_r, empty_r;
  logic [DBIT-1:0]   tx_din_r;
  logic [DBIT-1:0]   rd_data_s;
  logic              push_s, pop_s;

  // Acceptance looks only at the registered full flag, so a write while full
  // is dropped even if the FSM pops in the same cycle.
  assign push_s   = wr_en && !full_r;
  assign overflow = wr_en && full_r;

  uart_fifo_mem #(
    .DBIT   (DBIT),
    .ADDR_W (ADDR_W)
  ) u_mem (
    .clk     (clk),
    .wr_en   (push_s),
    .wr_addr (wr_ptr_r),
    .wr_data (wr_data),
    .rd_addr (rd_ptr_r),
    .rd_data (rd_data_s)
  );

  // issue FSM next-state and pop decision
  always_comb begin
    state_next_s = state_r;
    pop_s        = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (!empty_r) begin
          pop_s        = 1'b1;
          state_next_s = ST_ISSUE;
        end else begin
          state_next_s = ST_IDLE;
        end
      end
      ST_ISSUE: state_next_s = ST_WAIT;
      ST_WAIT: begin
        if (tx_done_tick) begin
          state_next_s = ST_IDLE;
        end else begin
          state_next_s = ST_WAIT;
        end
      end
      default: state_next_s = ST_IDLE;
    endcase
  end

  // occupancy update
  always_comb begin
    level_next_s = level_r;
    case ({push_s, pop_s})
      2'b10:   level_next_s = level_r + LVL_ONE;
      2'b01:   level_next_s = level_r - LVL_ONE;
      default: level_next_s = level_r;
    endcase
  end

  // pointers, level, flags, issued byte and FSM state
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r  <= ST_IDLE;
      wr_ptr_r <= PTR_ZERO;
      rd_ptr_r <= PTR_ZERO;
      level_r  <= LVL_ZERO;
      full_r   <= 1'b0;
      empty_r  <= 1'b1;
      tx_din_r <= DIN_ZERO;
    end else begin
      state_r <= state_next_s;
      if (push_s) begin
        wr_ptr_r <= wr_ptr_r + PTR_ONE;
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_ONE;
        tx_din_r <= rd_data_s;
      end
      level_r <= level_next_s;
      full_r  <= (level_next_s == LVL_FULL);
      empty_r <= (level_next_s == LVL_ZERO);
    end
  end

  assign full     = full_r;
  assign empty    = empty_r;
  assign level    = level_r;
  assign tx_din   = tx_din_r;
  assign tx_start = (state_r == ST_ISSUE);
  assign busy     = (state_r != ST_IDLE);

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed self-checking bench for uart_tx_fifo; the transmitter's done pulse
// is driven by hand at chosen cycles.
module tb_uart_tx_fifo;

  logic       clk = 1'b0;
  logic       reset;
  logic       wr_en;
  logic [7:0] wr_data;
  logic       full, empty, overflow, tx_start, busy, tx_done_tick;
  logic [4:0] level;
  logic [7:0] tx_din;

  int n_cmp = 0;
  int n_err = 0;
  int stray;
  int ovf_cnt;

  uart_tx_fifo dut (
    .clk          (clk),
    .reset        (reset),
    .wr_en        (wr_en),
    .wr_data      (wr_data),
    .full         (full),
    .empty        (empty),
    .level        (level),
    .overflow     (overflow),
    .tx_start     (tx_start),
    .tx_din       (tx_din),
    .tx_done_tick (tx_done_tick),
    .busy         (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic pulse_done();
    tx_done_tick = 1'b1;
    step(1);
    tx_done_tick = 1'b0;
  endtask

  initial begin
    reset = 1'b1; wr_en = 1'b0; wr_data = 8'h00; tx_done_tick = 1'b0;
    #12;
    check("rst_full", full, 0);
    check("rst_empty", empty, 1);
    check("rst_level", level, 0);
    check("rst_overflow", overflow, 0);
    check("rst_tx_start", tx_start, 0);
    check("rst_tx_din", tx_din, 0);
    check("rst_busy", busy, 0);
    @(posedge clk); #1;
    reset = 1'b0;
    step(1);

    // 1: single byte, done 160 cycles after tx_start
    wr_en = 1'b1; wr_data = 8'hA5;
    step(1);
    wr_en = 1'b0;
    check("t1_empty_after_write", empty, 0);
    check("t1_level_after_write", level, 1);
    check("t1_no_start_yet", tx_start, 0);
    step(1);
    check("t1_tx_start", tx_start, 1);
    check("t1_tx_din", tx_din, 8'hA5);
    check("t1_busy", busy, 1);
    check("t1_level_after_pop", level, 0);
    stray = 0;
    repeat (160) begin
      step(1);
      if (tx_start || !busy) stray = 1;
    end
    check("t1_wait_steady", stray, 0);
    check("t1_din_held", tx_din, 8'hA5);
    pulse_done();
    check("t1_idle_busy", busy, 0);
    check("t1_idle_empty", empty, 1);
    check("t1_idle_level", level, 0);
    step(2);

    // 2: burst 0x01..0x05
    for (int i = 0; i < 5; i++) begin
      wr_en = 1'b1; wr_data = 8'(i + 1);
      step(1);
      if (i == 1) begin
        check("t2_start_b1", tx_start, 1);
        check("t2_din_b1", tx_din, 8'h01);
      end
    end
    wr_en = 1'b0;
    check("t2_level_peak", level, 4);
    for (int b = 2; b <= 5; b++) begin
      step(3);
      pulse_done();
      check("t2_no_start_after_done", tx_start, 0);
      step(1);
      check("t2_start", tx_start, 1);
      check("t2_din_order", tx_din, b);
    end
    step(1);
    pulse_done();
    check("t2_end_busy", busy, 0);
    check("t2_end_level", level, 0);

    // 3: stalled transmitter, 17 writes behind an in-flight byte
    wr_en = 1'b1; wr_data = 8'h10;
    step(1);
    wr_en = 1'b0;
    step(2);
    check("t3_inflight_busy", busy, 1);
    ovf_cnt = 0;
    for (int i = 0; i < 17; i++) begin
      wr_en = 1'b1; wr_data = 8'(8'h20 + i);
      #1;
      if (overflow) ovf_cnt++;
      if (i == 15) check("t3_no_ovf_16th", overflow, 0);
      if (i == 16) check("t3_full_before_17th", full, 1);
      step(1);
    end
    wr_en = 1'b0;
    #1;
    check("t3_level_full", level, 16);
    check("t3_full", full, 1);
    check("t3_ovf_pulses", ovf_cnt, 1);
    check("t3_ovf_released", overflow, 0);

    // 4: push while full in the done cycle and in the pop cycle
    tx_done_tick = 1'b1; wr_en = 1'b1; wr_data = 8'hEE;
    #1;
    check("t4_ovf_done_cycle", overflow, 1);
    step(1);
    tx_done_tick = 1'b0;
    #1;
    check("t4_ovf_pop_cycle", overflow, 1);
    check("t4_idle", busy, 0);
    step(1);
    wr_en = 1'b0;
    check("t4_level_15", level, 15);
    check("t4_not_full", full, 0);
    check("t4_start", tx_start, 1);
    check("t4_din_first", tx_din, 8'h20);
    for (int k = 1; k < 16; k++) begin
      step(2);
      pulse_done();
      step(1);
      check("t3_drain_start", tx_start, 1);
      check("t3_drain_order", tx_din, 8'h20 + k);
    end
    check("t3_drained_empty", empty, 1);
    step(1);
    pulse_done();
    check("t3_drained_idle", busy, 0);

    // 4b: simultaneous push and pop at level 8
    for (int i = 0; i < 9; i++) begin
      wr_en = 1'b1; wr_data = 8'(8'h40 + i);
      step(1);
    end
    wr_en = 1'b0;
    check("t4_level_8", level, 8);
    pulse_done();
    wr_en = 1'b1; wr_data = 8'h49;
    step(1);
    wr_en = 1'b0;
    check("t4_level_stays_8", level, 8);
    check("t4_pop_din", tx_din, 8'h41);
    for (int k = 2; k <= 6; k++) begin
      step(1);
      pulse_done();
      step(1);
      check("t5_pre_order", tx_din, 8'h40 + k);
    end
    step(1);
    check("t5_level_3", level, 3);
    check("t5_in_wait", busy, 1);

    // 5: asynchronous reset during WAIT
    #2;
    reset = 1'b1;
    #1;
    check("t5_rst_start", tx_start, 0);
    check("t5_rst_busy", busy, 0);
    check("t5_rst_empty", empty, 1);
    check("t5_rst_level", level, 0);
    check("t5_rst_din", tx_din, 0);
    check("t5_rst_full", full, 0);
    @(posedge clk); #1;
    reset = 1'b0;
    stray = 0;
    repeat (10) begin
      step(1);
      if (tx_start || busy) stray = 1;
    end
    check("t5_no_spurious_start", stray, 0);

    // 6: done pulse while idle and empty
    pulse_done();
    check("t6_busy", busy, 0);
    check("t6_start", tx_start, 0);
    check("t6_empty", empty, 1);
    check("t6_level", level, 0);
    stray = 0;
    repeat (3) begin
      step(1);
      if (tx_start || busy) stray = 1;
    end
    check("t6_stays_idle", stray, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
